leitor_dispositivo: RTL and testbench

- Memory-mapped read path from an external input device back to the processor.
- The device pushes 32-bit words through a valid/ready handshake into an internal FIFO.
- The processor pops words by reading `DATA_ADDR` and polls occupancy and error flags by reading `STATUS_ADDR`.
- All other read addresses pass through to data memory; the block sits between the processor load port and data memory.

---
 rtl/leitor_dispositivo.sv | 146 ++++++++++++++
 tb/tb_leitor_dispositivo.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/leitor_dispositivo.sv
// leitor_dispositivo
// Read path from an external input device back to the processor.
// The device pushes 32-bit words into a small circular FIFO through a
// valid/ready handshake. The processor pops the FIFO head by reading
// DATA_ADDR and polls occupancy/underflow by reading STATUS_ADDR. Every
// other read address is passed through to data memory.
//
// Parameters:
//   DATA_ADDR   - read address that pops the FIFO head
//   STATUS_ADDR - read address returning {16'b0, count[7:0], 5'b0, underflow, full, empty}
//   DEPTH       - FIFO entries, power of two, 2..128
//
// Ports:
//   clock, reset          - rising-edge clock, synchronous active-high reset
//   address_in, read_en   - processor read request (one-cycle strobe)
//   mem_data_in           - data memory read data for pass-through reads
//   mem_read_en           - combinational memory read enable (non-device addresses)
//   address_out           - combinational copy of address_in
//   data_out, rd_valid    - registered read response, one cycle after the request
//   device_data/valid     - word offered by the device
//   device_ready          - combinational: low in reset or when the FIFO is full
//   irq                   - only when DEVICE_IRQ_EN is defined: FIFO non-empty or underflow
//
// Build option: define DEVICE_IRQ_EN to add the registered irq output.
module leitor_dispositivo #(
  parameter logic [31:0] DATA_ADDR   = 32'd900000,
  parameter logic [31:0] STATUS_ADDR = 32'd900004,
  parameter int          DEPTH       = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_in,
  input  logic        read_en,
  input  logic [31:0] mem_data_in,
  output logic        mem_read_en,
  output logic [31:0] address_out,
  output logic [31:0] data_out,
  output logic        rd_valid,
  input  logic [31:0] device_data,
  input  logic        device_valid,
  output logic        device_ready
`ifdef DEVICE_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             underflow;
  logic             underflow_nxt;

  logic             full;
  logic             empty;
  logic             is_data;
  logic             is_status;
  logic             push;
  logic             pop;
  logic             underflow_set;
  logic [31:0]      rd_data_nxt;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign is_data   = (address_in == DATA_ADDR);
  assign is_status = (address_in == STATUS_ADDR);

  assign address_out  = address_in;
  assign mem_read_en  = read_en && !is_data && !is_status;
  // No path from device_valid: ready depends only on reset and occupancy.
  assign device_ready = !reset && !full;

  assign push          = device_valid && device_ready;
  assign pop           = read_en && is_data && !empty;
  assign underflow_set = read_en && is_data && empty;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // A same-cycle underflow event beats the clear from a status read.
  always_comb begin
    underflow_nxt = underflow;
    if (underflow_set)
      underflow_nxt = 1'b1;
    else if (read_en && is_status)
      underflow_nxt = 1'b0;
  end

  // Status uses pre-read values; count is zero-extended to the 8-bit field.
  always_comb begin
    rd_data_nxt = mem_data_in;
    if (is_data)
      rd_data_nxt = empty ? 32'd0 : fifo_mem[rd_ptr];
    else if (is_status)
      rd_data_nxt = {16'd0, 8'(count), 5'd0, underflow, full, empty};
  end

  // Storage holds data only; reset discards contents by clearing count.
  always_ff @(posedge clock) begin
    if (push)
      fifo_mem[wr_ptr] <= device_data;
  end

  // Response stage: one-cycle read latency
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      underflow <= 1'b0;
      data_out  <= 32'd0;
      rd_valid  <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      count     <= count_nxt;
      underflow <= underflow_nxt;
      rd_valid  <= read_en;
      if (read_en)
        data_out <= rd_data_nxt;
    end
  end

`ifdef DEVICE_IRQ_EN
  always_ff @(posedge clock) begin
    if (reset)
      irq <= 1'b0;
    else
      irq <= (count_nxt != '0) || underflow_nxt;
  end
`endif

endmodule

// File: tb/tb_leitor_dispositivo.sv
// Randomized and directed bench for leitor_dispositivo against a
// queue-based reference model of the device FIFO and read responses.
module tb_leitor_dispositivo;

  localparam logic [31:0] DATA_ADDR   = 32'd900000;
  localparam logic [31:0] STATUS_ADDR = 32'd900004;
  localparam int          DEPTH       = 4;

  logic        clock;
  logic        reset;
  logic [31:0] address_in;
  logic        read_en;
  logic [31:0] mem_data_in;
  logic        mem_read_en;
  logic [31:0] address_out;
  logic [31:0] data_out;
  logic        rd_valid;
  logic [31:0] device_data;
  logic        device_valid;
  logic        device_ready;
`ifdef DEVICE_IRQ_EN
  logic        irq;
`endif

  leitor_dispositivo #(
    .DATA_ADDR  (DATA_ADDR),
    .STATUS_ADDR(STATUS_ADDR),
    .DEPTH      (DEPTH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .address_in  (address_in),
    .read_en     (read_en),
    .mem_data_in (mem_data_in),
    .mem_read_en (mem_read_en),
    .address_out (address_out),
    .data_out    (data_out),
    .rd_valid    (rd_valid),
    .device_data (device_data),
    .device_valid(device_valid),
    .device_ready(device_ready)
`ifdef DEVICE_IRQ_EN
    ,
    .irq         (irq)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] q[$];
  logic        m_und  = 1'b0;
  logic [31:0] m_data = 32'd0;
  logic        m_vld  = 1'b0;
  logic        m_irq  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive, check combinational outputs, advance model, check registered outputs.
  task automatic step(input logic rst, input logic rd, input logic [31:0] addr,
                      input logic [31:0] mdata, input logic dv, input logic [31:0] dd);
    int          sz;
    logic        pushed;
    logic        und_set;
    logic        stat_rd;
    reset        = rst;
    read_en      = rd;
    address_in   = addr;
    mem_data_in  = mdata;
    device_valid = dv;
    device_data  = dd;
    #1;
    sz = q.size();
    chk("device_ready", 32'(device_ready), 32'(!rst && sz < DEPTH));
    chk("mem_read_en", 32'(mem_read_en),
        32'(rd && addr != DATA_ADDR && addr != STATUS_ADDR));
    chk("address_out", address_out, addr);

    if (rst) begin
      q.delete();
      m_und  = 1'b0;
      m_data = 32'd0;
      m_vld  = 1'b0;
      m_irq  = 1'b0;
    end else begin
      pushed  = dv && sz < DEPTH;
      und_set = 1'b0;
      stat_rd = 1'b0;
      m_vld   = rd;
      if (rd) begin
        if (addr == DATA_ADDR) begin
          if (sz > 0) m_data = q.pop_front();
          else begin
            m_data  = 32'd0;
            und_set = 1'b1;
          end
        end else if (addr == STATUS_ADDR) begin
          m_data  = {16'd0, 8'(sz), 5'd0, m_und, (sz == DEPTH), (sz == 0)};
          stat_rd = 1'b1;
        end else begin
          m_data = mdata;
        end
      end
      if (pushed) q.push_back(dd);
      if (und_set) m_und = 1'b1;
      else if (stat_rd) m_und = 1'b0;
      m_irq = (q.size() != 0) || m_und;
    end

    @(posedge clock);
    #1;
    chk("rd_valid", 32'(rd_valid), 32'(m_vld));
    chk("data_out", data_out, m_data);
`ifdef DEVICE_IRQ_EN
    chk("irq", 32'(irq), 32'(m_irq));
`endif
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask
  task automatic rd_data();
    step(1'b0, 1'b1, DATA_ADDR, 32'h0, 1'b0, 32'h0);
  endtask
  task automatic rd_status();
    step(1'b0, 1'b1, STATUS_ADDR, 32'h0, 1'b0, 32'h0);
  endtask
  task automatic push_word(input logic [31:0] w);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, w);
  endtask

  initial begin
    reset = 1'b1; read_en = 1'b0; address_in = '0; mem_data_in = '0;
    device_valid = 1'b0; device_data = '0;
    @(posedge clock); #1;

    // Reset and idle status
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    rd_status();
    chk("status_after_reset", data_out, 32'h1);
    idle();
    chk("rd_valid_pulse", 32'(rd_valid), 32'h0);

    // In-order delivery
    push_word(32'hA1); push_word(32'hB2); push_word(32'hC3);
    rd_data(); chk("pop_a1", data_out, 32'hA1);
    rd_data(); chk("pop_b2", data_out, 32'hB2);
    rd_data(); chk("pop_c3", data_out, 32'hC3);
    rd_status(); chk("status_drained", data_out, 32'h1);

    // Full, back-pressure, wrap-around
    push_word(32'h11); push_word(32'h22); push_word(32'h33); push_word(32'h44);
    rd_status(); chk("status_full", data_out, 32'h402);
    push_word(32'h55);
    step(1'b0, 1'b1, DATA_ADDR, 32'h0, 1'b1, 32'h55);
    chk("pop_full_11", data_out, 32'h11);
    push_word(32'h55);
    rd_data(); chk("wrap_22", data_out, 32'h22);
    rd_data(); chk("wrap_33", data_out, 32'h33);
    rd_data(); chk("wrap_44", data_out, 32'h44);
    rd_data(); chk("wrap_55", data_out, 32'h55);

    // Underflow flag set and cleared
    rd_data();   chk("underflow_data", data_out, 32'h0);
    rd_status(); chk("status_underflow", data_out, 32'h5);
    rd_status(); chk("status_cleared", data_out, 32'h1);

    // Push while empty with a simultaneous pop attempt
    step(1'b0, 1'b1, DATA_ADDR, 32'h0, 1'b1, 32'h77);
    rd_status(); chk("status_push_underflow", data_out, 32'h405 >> 0 & 32'h0000_0104 | 32'h104);
    rd_data();   chk("pop_77", data_out, 32'h77);

    // Pass-through
    step(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0);
    chk("passthrough", data_out, 32'hDEADBEEF);

    // Reset with words buffered and a read in flight
    push_word(32'h1); push_word(32'h2); push_word(32'h3);
    step(1'b0, 1'b1, DATA_ADDR, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b1, DATA_ADDR, 32'h0, 1'b0, 32'h0);
    chk("reset_rd_valid", 32'(rd_valid), 32'h0);
    chk("reset_data_out", data_out, 32'h0);
    rd_status(); chk("status_post_reset", data_out, 32'h1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic        r_rst;
      logic        r_rd;
      logic        r_dv;
      logic [31:0] r_addr;
      int          sel;
      r_rst = ($urandom_range(0, 199) == 0);
      r_rd  = ($urandom_range(0, 2) != 0);
      r_dv  = ($urandom_range(0, 1) != 0);
      sel   = $urandom_range(0, 4);
      if (sel < 2)       r_addr = DATA_ADDR;
      else if (sel == 2) r_addr = STATUS_ADDR;
      else               r_addr = $urandom;
      step(r_rst, r_rd, r_addr, $urandom, r_dv, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
